// File: rtl/apb_bridge_axil.sv
// apb_bridge_axil
//   AXI4-Lite slave to APB master bridge. Exactly one AXI4-Lite read or write
//   is in flight at a time. Each one becomes a single APB SETUP/ACCESS
//   transfer, and its result is returned on the matching AXI response channel.
//
// Ports
//   clock, reset        : clock; synchronous active-high reset
//   s_aw*/s_w*/s_b*     : AXI4-Lite write address / data / response channels
//   s_ar*/s_r*          : AXI4-Lite read address / data channels
//   paddr..pstrb        : APB master request outputs (all registered)
//   pready/prdata/pslverr : APB completion inputs
//
// Handshakes: a beat transfers on a rising edge where valid and ready are both
// high. A write request exists only while s_awvalid and s_wvalid are both high.
// Ready outputs are registered, so ready is raised one cycle ahead of the
// acceptance edge. Once a response valid is raised, it stays high and its
// payload stays stable until the matching ready is sampled high.
module apb_bridge_axil #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic [2:0]  s_awprot,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    input  logic [2:0]  s_arprot,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic [2:0]  pprot,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    input  logic        pready,
    input  logic [31:0] prdata,
    input  logic        pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [1:0]  OKAY     = 2'b00;
    localparam logic [1:0]  SLVERR   = 2'b10;

    state_t      state;
    logic        last_write;  // direction of the most recently accepted request
    logic [15:0] wait_cnt;

    logic wr_req, rd_req, any_req, pick_write;
    logic accept_wr, accept_rd, resp_done, timeout_hit;

    assign wr_req  = s_awvalid && s_wvalid;
    assign rd_req  = s_arvalid;
    assign any_req = wr_req || rd_req;
    // On a tie, the direction opposite to the last one served wins.
    assign pick_write  = wr_req && !(rd_req && last_write);
    assign accept_wr   = s_awready && s_wready && wr_req;
    assign accept_rd   = s_arready && s_arvalid;
    assign resp_done   = (s_bvalid && s_bready) || (s_rvalid && s_rready);
    // Abort fires on the edge where the wait count would reach the limit.
    assign timeout_hit = TO_EN && ((wait_cnt + 16'd1) == TO_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_write <= 1'b1;
            wait_cnt   <= '0;
            s_awready  <= 1'b0;
            s_wready   <= 1'b0;
            s_arready  <= 1'b0;
            s_bvalid   <= 1'b0;
            s_bresp    <= OKAY;
            s_rvalid   <= 1'b0;
            s_rdata    <= '0;
            s_rresp    <= OKAY;
            paddr      <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pprot      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            pstrb      <= '0;
        end else begin
            // Ready outputs are single-cycle pulses.
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_arready <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_wr) begin
                        paddr      <= s_awaddr;
                        pprot      <= s_awprot;
                        pwrite     <= 1'b1;
                        pwdata     <= s_wdata;
                        pstrb      <= s_wstrb;
                        psel       <= 1'b1;
                        last_write <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= SETUP;
                    end else if (accept_rd) begin
                        paddr      <= s_araddr;
                        pprot      <= s_arprot;
                        pwrite     <= 1'b0;
                        pstrb      <= '0;
                        psel       <= 1'b1;
                        last_write <= 1'b0;
                        wait_cnt   <= '0;
                        state      <= SETUP;
                    end else if (any_req && !(s_awready || s_arready)) begin
                        s_awready <= pick_write;
                        s_wready  <= pick_write;
                        s_arready <= !pick_write;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready || timeout_hit) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= RESP;
                        if (pwrite) begin
                            s_bvalid <= 1'b1;
                            s_bresp  <= (pready && !pslverr) ? OKAY : SLVERR;
                        end else begin
                            s_rvalid <= 1'b1;
                            s_rresp  <= (pready && !pslverr) ? OKAY : SLVERR;
                        end
                        if (!pready) begin
                            s_rdata <= '0;
                        end else if (!pwrite) begin
                            s_rdata <= prdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (resp_done) begin
                        s_bvalid <= 1'b0;
                        s_rvalid <= 1'b0;
                        state    <= IDLE;
                        // Raise ready now so acceptance can land on the next edge.
                        if (any_req) begin
                            s_awready <= pick_write;
                            s_wready  <= pick_write;
                            s_arready <= !pick_write;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
